// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: launch/operand/MTHI-MTLO inputs and Busy/Done/Hi/Lo outputs of the multiply/divide unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       MdOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiWe;
  logic             LoWe;
  logic [WIDTH-1:0] WData;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  modport master (output Start, MdOp, A, B, HiWe, LoWe, WData, input Busy, Done, Hi, Lo);
  modport slave (input Start, MdOp, A, B, HiWe, LoWe, WData, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO; CLK, Reset, bus (Start/MdOp/A/B/HiWe/LoWe/WData in, Busy/Done/Hi/Lo out)
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input logic CLK,
  input logic Reset,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [1:0] op;
  logic [WIDTH-1:0] mag_b, a_raw, hw, lw, hi, lo, div_sub, quo_fix, rem_fix;
  logic [CNTW-1:0] cnt;
  logic neg_res, neg_div, dz, done, a_neg, b_neg, div_ok;
  logic [WIDTH:0] mul_sum, div_sh;
  logic [2*WIDTH-1:0] prod_fix;
  assign bus.Busy = state != IDLE;
  assign bus.Done = done;
  assign bus.Hi = hi;
  assign bus.Lo = lo;
  always_comb begin
    a_neg = bus.MdOp[0] & bus.A[WIDTH-1];
    b_neg = bus.MdOp[0] & bus.B[WIDTH-1];
    mul_sum = {1'b0, hw} + {1'b0, mag_b & {WIDTH{lw[0]}}};
    div_sh = {hw, lw[WIDTH-1]};
    div_ok = div_sh >= {1'b0, mag_b};
    div_sub = div_sh[WIDTH-1:0] - mag_b;
    prod_fix = neg_res ? -{hw, lw} : {hw, lw};
    quo_fix = neg_res ? -lw : lw;
    rem_fix = neg_div ? -hw : hw;
    state_nx = state == IDLE ? (bus.Start ? CALC : IDLE) :
               state == CALC ? (cnt == CNTW'(1) ? FIX : CALC) : IDLE;
  end
  always_ff @(posedge CLK)
    state <= Reset ? IDLE : state_nx;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      op <= '0;
      mag_b <= '0;
      a_raw <= '0;
      hw <= '0;
      lw <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      neg_res <= 1'b0;
      neg_div <= 1'b0;
      dz <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == FIX;
      case (state)
        IDLE:
          if (bus.Start) begin
            op <= bus.MdOp;
            mag_b <= b_neg ? -bus.B : bus.B;
            lw <= a_neg ? -bus.A : bus.A;
            hw <= '0;
            a_raw <= bus.A;
            neg_res <= a_neg ^ b_neg;
            neg_div <= a_neg;
            dz <= bus.MdOp[1] && bus.B == '0;
            cnt <= CNTW'(WIDTH);
          end else begin
            if (bus.HiWe) hi <= bus.WData;
            if (bus.LoWe) lo <= bus.WData;
          end
        CALC: begin
          cnt <= cnt - CNTW'(1);
          hw <= op[1] ? (div_ok ? div_sub : div_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
          lw <= op[1] ? {lw[WIDTH-2:0], div_ok} : {mul_sum[0], lw[WIDTH-1:1]};
        end
        FIX: begin
          hi <= op[1] ? (dz ? a_raw : rem_fix) : prod_fix[2*WIDTH-1:WIDTH];
          lo <= op[1] ? (dz ? '1 : quo_fix) : prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed hand-computed vectors
module tb_muldiv_unit;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int sc;
    string name;
  } exp_t;
  exp_t q[$];
  muldiv_unit_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32), .CNTW(6)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  always @(negedge CLK) begin
    if (bus.Done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done at cycle %0d: got Done=1 expected 0", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_hi"}, bus.Hi, e.hi);
        chk({e.name, "_lo"}, bus.Lo, e.lo);
        chk({e.name, "_latency"}, 32'(cyc - e.sc), 32'd34);
      end
    end
  end
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done, input logic [31:0] eh, input logic [31:0] el,
                       input string name);
    exp_t e;
    bus.Start = 1'b1;
    bus.MdOp = op;
    bus.A = a;
    bus.B = b;
    e.hi = eh;
    e.lo = el;
    e.sc = cyc;
    e.name = name;
    if (expect_done) q.push_back(e);
    step();
    bus.Start = 1'b0;
    bus.A = ~a;
    bus.B = ~b;
    bus.MdOp = ~op;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while ((q.size() != 0 || bus.Busy) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got still busy after %0d cycles expected idle", name, n);
    end
  endtask
  initial begin
    int bad;
    bus.Start = 1'b0;
    bus.MdOp = 2'b00;
    bus.A = '0;
    bus.B = '0;
    bus.HiWe = 1'b0;
    bus.LoWe = 1'b0;
    bus.WData = '0;
    repeat (2) step();
    Reset = 1'b0;
    @(negedge CLK);
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    chk("reset_done", 32'(bus.Done), 32'd0);
    chk("reset_hi", bus.Hi, 32'd0);
    chk("reset_lo", bus.Lo, 32'd0);
    step();
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge CLK);
      if (bus.Busy !== 1'b1) bad++;
    end
    chk("busy_window_bad_cycles", 32'(bad), 32'd0);
    @(negedge CLK);
    chk("busy_drop_cycle34", 32'(bus.Busy), 32'd0);
    wait_idle("multu_max");
    issue(2'b01, 32'hFFFFFFFD, 32'd7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7");
    wait_idle("mult_neg3x7");
    issue(2'b01, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, "mult_min_sq");
    wait_idle("mult_min_sq");
    issue(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, "divu_100_7");
    wait_idle("divu_100_7");
    issue(2'b11, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
    wait_idle("div_m7_2");
    issue(2'b11, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFD, "div_7_m2");
    wait_idle("div_7_m2");
    issue(2'b10, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFFFFFF, "divu_by_zero");
    wait_idle("divu_by_zero");
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, "div_overflow");
    wait_idle("div_overflow");
    issue(2'b00, 32'h00010000, 32'h00010000, 1'b1, 32'd1, 32'd0, "busy_ignore");
    repeat (4) step();
    bus.Start = 1'b1;
    bus.MdOp = 2'b00;
    bus.A = 32'd9;
    bus.B = 32'd9;
    bus.HiWe = 1'b1;
    bus.WData = 32'hDEADBEEF;
    step();
    bus.Start = 1'b0;
    bus.HiWe = 1'b0;
    wait_idle("busy_ignore");
    checks++;
    if (bus.Hi === 32'hDEADBEEF) begin
      failures++;
      $display("FAIL busy_hiwe_dropped: got %h expected not deadbeef", bus.Hi);
    end
    issue(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0, 32'h0, 32'h0, "reset_abort");
    repeat (9) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    @(negedge CLK);
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_hi", bus.Hi, 32'd0);
    chk("abort_lo", bus.Lo, 32'd0);
    repeat (40) step();
    bus.HiWe = 1'b1;
    bus.WData = 32'h12345678;
    step();
    bus.HiWe = 1'b0;
    @(negedge CLK);
    chk("mthi", bus.Hi, 32'h12345678);
    chk("mthi_lo_untouched", bus.Lo, 32'd0);
    step();
    bus.LoWe = 1'b1;
    bus.WData = 32'hAAAAAAAA;
    issue(2'b00, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, "multu_2x3_start_wins");
    bus.LoWe = 1'b0;
    @(negedge CLK);
    chk("start_wins_lo_not_written", bus.Lo, 32'd0);
    wait_idle("multu_2x3_start_wins");
    bus.HiWe = 1'b1;
    bus.LoWe = 1'b1;
    bus.WData = 32'h55AA33CC;
    step();
    bus.HiWe = 1'b0;
    bus.LoWe = 1'b0;
    @(negedge CLK);
    chk("both_we_hi", bus.Hi, 32'h55AA33CC);
    chk("both_we_lo", bus.Lo, 32'h55AA33CC);
    step();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
